mult_seq: RTL and testbench

- Parametrised iterative shift-add multiplier. It is the successor to the team's fixed 12x12 single-cycle multiplier.
- Trades latency for area by retiring BITS_PER_CYCLE multiplier bits per clock.
- Adds per-operation signed/unsigned mode and a busy/start/done handshake.
- Sits beside the datapath as a shared arithmetic unit driven by a controller FSM.

---
 rtl/mult_seq_if.sv | 32 +++
 rtl/mult_seq.sv | 127 ++++++++++++
 tb/tb_mult_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mult_seq_if.sv
// Operand/result bus for mult_seq. The accumulate strobe exists only when
// MULT_SEQ_ACC_EN is defined.
interface mult_seq_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               signed_mode;
   logic               start;
   logic               busy;
   logic [2*WIDTH-1:0] result;
   logic               done;
`ifdef MULT_SEQ_ACC_EN
   logic               accumulate;
`endif

   modport master (
`ifdef MULT_SEQ_ACC_EN
      output accumulate,
`endif
      output a, b, signed_mode, start,
      input  busy, result, done
   );

   modport slave (
`ifdef MULT_SEQ_ACC_EN
      input  accumulate,
`endif
      input  a, b, signed_mode, start,
      output busy, result, done
   );
endinterface

// File: rtl/mult_seq.sv
// Iterative shift-add multiplier, BITS_PER_CYCLE multiplier bits per clock.
// Optional multiply-accumulate into result when MULT_SEQ_ACC_EN is defined.
module mult_seq #(
   parameter int WIDTH          = 16,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic       clk,
   input  logic       reset,
   mult_seq_if.slave  bus
);
   localparam int N     = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = $clog2(N + 1);
   localparam int RW    = 2 * WIDTH;

   if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) ||
       (WIDTH % BITS_PER_CYCLE) != 0 || WIDTH < 4 || WIDTH > 32) begin : g_bad_param
      $error("mult_seq: illegal WIDTH/BITS_PER_CYCLE combination");
   end

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

   state_e             state_q, state_d;
   logic [RW-1:0]      mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [RW-1:0]      acc_q, acc_d;
   logic [RW-1:0]      result_q, result_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sign_q, sign_d;
   logic               done_q, done_d;
   logic               acc_en_q, acc_en_d;

   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [RW-1:0]      pp, prod;
   logic               acc_req;

`ifdef MULT_SEQ_ACC_EN
   assign acc_req = bus.accumulate;
`else
   assign acc_req = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         sign_q   <= 1'b0;
         done_q   <= 1'b0;
         acc_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         sign_q   <= sign_d;
         done_q   <= done_d;
         acc_en_q <= acc_en_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (cnt_q == CNT_W'(1)) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Multiplicand is pre-shifted each iteration, so the partial product only
   // ever looks at the low BITS_PER_CYCLE multiplier bits.
   always_comb begin
      pp = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++)
         if (mplier_q[i]) pp = pp + (mcand_q << i);
   end

   always_comb begin
      a_mag = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      b_mag = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
      prod  = sign_q ? -acc_q : acc_q;
   end

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      sign_d   = sign_q;
      acc_en_d = acc_en_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: if (bus.start) begin
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            acc_d    = '0;
            cnt_d    = CNT_W'(N);
            sign_d   = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc_en_d = acc_req;
         end
         RUN: begin
            acc_d    = acc_q + pp;
            mcand_d  = mcand_q << BITS_PER_CYCLE;
            mplier_d = mplier_q >> BITS_PER_CYCLE;
            cnt_d    = cnt_q - CNT_W'(1);
         end
         FIX: begin
            result_d = acc_en_q ? result_q + prod : prod;
            done_d   = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.busy   = (state_q != IDLE);
      bus.done   = done_q;
      bus.result = result_q;
   end
endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: vector table + random ops through a
// scoreboard queue, plus hand-written handshake/reset/latency sequences.
module tb_mult_seq;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mult_seq_if #(.WIDTH(16)) bus1 ();
   mult_seq_if #(.WIDTH(16)) bus4 ();

   mult_seq #(.WIDTH(16), .BITS_PER_CYCLE(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
   mult_seq #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sm;
      logic [31:0] exp;
   } vec_t;

   logic [31:0] q1[$];
   logic [31:0] q4[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && bus1.done) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_done1: got done=1 with result 0x%08h, expected no done", bus1.result);
         end else chk("result1", bus1.result, q1.pop_front());
      end
      if (!reset && bus4.done) begin
         if (q4.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_done4: got done=1 with result 0x%08h, expected no done", bus4.result);
         end else chk("result4", bus4.result, q4.pop_front());
      end
   end

   // Called on the negedge right after the start edge; cyc = edges to done.
   task automatic wait_done1(output int cyc, output int bcnt);
      cyc = 0; bcnt = 0;
      while (!bus1.done && cyc < 100) begin
         if (bus1.busy) bcnt++;
         @(negedge clk);
         cyc++;
      end
      if (!bus1.done) begin
         checks++; errors++;
         $display("FAIL timeout1: got no done after %0d cycles, expected done", cyc);
      end
   endtask

   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic sm,
                        input logic [31:0] exp);
      int cyc, bcnt;
      @(negedge clk);
      bus1.a = a; bus1.b = b; bus1.signed_mode = sm; bus1.start = 1'b1;
      q1.push_back(exp);
      @(negedge clk);
      bus1.start = 1'b0;
      bus1.a = $urandom; bus1.b = $urandom; bus1.signed_mode = $urandom;
      wait_done1(cyc, bcnt);
      chk("latency", 32'(cyc), 32'd17);
      chk("busy_cycles", 32'(bcnt), 32'd17);
      chk("busy_at_done", {31'b0, bus1.busy}, 32'd0);
   endtask

   initial begin
      vec_t vecs[8];
      int cyc, bcnt;
      logic [15:0] ra, rb;
      logic        rs;
      logic signed [31:0] sp;

      vecs[0] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
      vecs[1] = '{16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1};
      vecs[2] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000};
      vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001};
      vecs[4] = '{16'h0000, 16'h1234, 1'b0, 32'h00000000};
      vecs[5] = '{16'h8000, 16'h0001, 1'b1, 32'hFFFF8000};
      vecs[6] = '{16'h7FFF, 16'h8000, 1'b1, 32'hC0008000};
      vecs[7] = '{16'h8000, 16'h0002, 1'b0, 32'h00010000};

      reset = 1'b1;
      bus1.a = '0; bus1.b = '0; bus1.signed_mode = 1'b0; bus1.start = 1'b0;
      bus4.a = '0; bus4.b = '0; bus4.signed_mode = 1'b0; bus4.start = 1'b0;
`ifdef MULT_SEQ_ACC_EN
      bus1.accumulate = 1'b0;
      bus4.accumulate = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'b0, bus1.busy}, 32'd0);
      chk("rst_done", {31'b0, bus1.done}, 32'd0);
      chk("rst_result", bus1.result, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) do_op(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp);

      for (int i = 0; i < 10; i++) begin
         ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
         sp = $signed({{16{ra[15]}}, ra}) * $signed({{16{rb[15]}}, rb});
         do_op(ra, rb, rs, rs ? 32'(sp) : 32'(ra) * 32'(rb));
      end

      // start during busy is ignored; start in the done cycle is accepted
      @(negedge clk);
      bus1.a = 16'd2; bus1.b = 16'd3; bus1.signed_mode = 1'b0; bus1.start = 1'b1;
      q1.push_back(32'd6);
      @(negedge clk);
      bus1.start = 1'b0;
      repeat (3) @(negedge clk);
      bus1.a = 16'd7; bus1.b = 16'd7; bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      wait_done1(cyc, bcnt);
      bus1.a = 16'd4; bus1.b = 16'd5; bus1.start = 1'b1;
      q1.push_back(32'd20);
      @(negedge clk);
      bus1.start = 1'b0;
      wait_done1(cyc, bcnt);
      chk("b2b_latency", 32'(cyc), 32'd17);

      // reset mid-operation aborts with no done
      @(negedge clk);
      bus1.a = 16'h1111; bus1.b = 16'h2222; bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", {31'b0, bus1.busy}, 32'd0);
      chk("abort_result", bus1.result, 32'd0);
      repeat (25) @(negedge clk);
      chk("abort_result_held", bus1.result, 32'd0);
      do_op(16'd10, 16'd10, 1'b0, 32'd100);

      // BITS_PER_CYCLE=4 instance: N=4, done after 5 edges
      @(negedge clk);
      bus4.a = 16'h1234; bus4.b = 16'h5678; bus4.signed_mode = 1'b0; bus4.start = 1'b1;
      q4.push_back(32'h06260060);
      @(negedge clk);
      bus4.start = 1'b0;
      cyc = 0;
      while (!bus4.done && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("latency4", 32'(cyc), 32'd5);
      @(negedge clk);
      bus4.a = 16'hFFFD; bus4.b = 16'h0005; bus4.signed_mode = 1'b1; bus4.start = 1'b1;
      q4.push_back(32'hFFFFFFF1);
      @(negedge clk);
      bus4.start = 1'b0;
      repeat (8) @(negedge clk);

`ifdef MULT_SEQ_ACC_EN
      bus1.accumulate = 1'b0;
      do_op(16'd3, 16'd4, 1'b0, 32'd12);
      bus1.accumulate = 1'b1;
      do_op(16'd5, 16'd6, 1'b0, 32'd42);
      bus1.accumulate = 1'b0;
`endif

      repeat (5) @(negedge clk);
      chk("pending1", 32'(q1.size()), 32'd0);
      chk("pending4", 32'(q4.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
